// File: rtl/logger_uart_tx.sv
// logger_uart_tx: drains the logger FWFT byte FIFO onto a UART TX pin.
// Frame: start bit, 8 data bits LSB first, optional even parity bit,
// STOP_BITS stop bits. The line idles high.
// Optional feature macro: LOGGER_UART_TX_PARITY_EN (adds an even parity bit).
// dbg_state exposes the FSM state encoding for observation.
module logger_uart_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] bytes_sent,
  output logic [2:0]  dbg_state
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOGGER_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic            stop_idx;
  logic [7:0]      shift_reg;
  logic            armed;
`ifdef LOGGER_UART_TX_PARITY_EN
  logic            par_bit;
`endif

  logic bit_end;
  logic last_stop;
  logic pop;

  // Pop decision: idle or final stop cycle, enabled, data present, and not
  // in the first cycle out of reset (armed keeps rd_en low during reset).
  always_comb begin
    bit_end    = (timer == T_LAST);
    last_stop  = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
    pop        = armed && enable && !fifo_empty &&
                 ((state == S_IDLE) || last_stop);
    fifo_rd_en = pop;
    busy       = (state != S_IDLE);
    dbg_state  = state;
  end

  // Frame FSM: bit timer, data shifting, registered tx and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      bytes_sent <= '0;
      armed      <= 1'b0;
`ifdef LOGGER_UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (pop) begin
            shift_reg <= fifo_dout;
`ifdef LOGGER_UART_TX_PARITY_EN
            par_bit   <= ^fifo_dout;
`endif
            tx        <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift_reg[0];
            state   <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer     <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef LOGGER_UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= S_PARITY;
`else
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
`ifdef LOGGER_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            timer    <= '0;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (stop_idx == STOP_LAST) begin
              bytes_sent <= bytes_sent + 16'd1;
              // Back-to-back: the next start bit follows with no idle gap.
              if (pop) begin
                shift_reg <= fifo_dout;
`ifdef LOGGER_UART_TX_PARITY_EN
                par_bit   <= ^fifo_dout;
`endif
                tx        <= 1'b0;
                state     <= S_START;
              end else begin
                tx    <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logger_uart_tx.sv
// Testbench for logger_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1.
// A small FWFT FIFO model feeds the DUT; a UART monitor decodes frames from tx
// and compares them with bytes queued in exp_q when they were pushed.
module tb_logger_uart_tx;

  localparam int CPB   = 4;
  localparam int STOPB = 1;
`ifdef LOGGER_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = 10 + STOPB - 1 + PAR;
  localparam int FC = FB * CPB;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;
  logic [2:0]  dbg_state;

  logger_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .tx(tx), .busy(busy), .bytes_sent(bytes_sent), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // expected bytes: {hand parity, data}
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FWFT FIFO model
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) begin
        errors++;
        $display("FAIL rd_en_while_empty actual=1 required=0");
      end else begin
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] b, input logic p, input bit expect_it);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
    if (expect_it) exp_q.push_back({p, b});
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) check(name, 32'(busy), 32'(lvl));
  endtask

  task automatic count_busy(output int n);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  // monitor / scoreboard
  logic s_buf [0:FC-1];
  int mon_cnt = -1;

  task automatic check_frame();
    logic stable;
    logic [7:0] data;
    logic stops;
    logic [8:0] e;
    stable = 1'b1;
    for (int b = 0; b < FB; b++)
      for (int k = 1; k < CPB; k++)
        if (s_buf[b*CPB+k] !== s_buf[b*CPB]) stable = 1'b0;
    for (int b = 0; b < 8; b++) data[b] = s_buf[(b+1)*CPB];
    stops = 1'b1;
    for (int b = 9 + PAR; b < FB; b++) if (s_buf[b*CPB] !== 1'b1) stops = 1'b0;
    check("bit_stable", 32'(stable), 32'd1);
    check("stop_bits", 32'(stops), 32'd1);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'(data), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("frame_data", 32'(data), 32'(e[7:0]));
`ifdef LOGGER_UART_TX_PARITY_EN
      check("parity_bit", 32'(s_buf[9*CPB]), 32'(e[8]));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt = -1;
    end else if (mon_cnt < 0) begin
      if (tx === 1'b0) begin
        s_buf[0] = 1'b0;
        mon_cnt = 1;
      end
    end else begin
      s_buf[mon_cnt] = tx;
      mon_cnt++;
      if (mon_cnt == FC) begin
        check_frame();
        mon_cnt = -1;
      end
    end
  end

  // stimulus
  initial begin
    int n;
    int p0;
    logic bad_tx, bad_rd, bad_busy;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bytes_sent", 32'(bytes_sent), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // single byte 0xA5
    p0 = rd_ptr;
    push(8'hA5, 1'b0, 1);
    wait_busy(1'b1, 10, "a5_busy_rise");
    check("a5_first_tx_low", 32'(tx), 32'd0);
    count_busy(n);
    check("a5_busy_len", 32'(n), 32'(FC));
    check("a5_pops", 32'(rd_ptr - p0), 32'd1);
    check("a5_bytes_sent", 32'(bytes_sent), 32'd1);
    check("a5_tx_idle", 32'(tx), 32'd1);

    // back-to-back 0x00, 0xFF, 0x55
    repeat (2) @(negedge clk);
    p0 = rd_ptr;
    push(8'h00, 1'b0, 1);
    push(8'hFF, 1'b0, 1);
    push(8'h55, 1'b0, 1);
    wait_busy(1'b1, 10, "b2b_busy_rise");
    count_busy(n);
    check("b2b_busy_len", 32'(n), 32'(3 * FC));
    check("b2b_pops", 32'(rd_ptr - p0), 32'd3);
    check("b2b_bytes_sent", 32'(bytes_sent), 32'd4);

    // empty FIFO idle
    bad_tx = 1'b0; bad_rd = 1'b0; bad_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx = 1'b1;
      if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("idle_tx_high", 32'(bad_tx), 32'd0);
    check("idle_no_rd_en", 32'(bad_rd), 32'd0);
    check("idle_not_busy", 32'(bad_busy), 32'd0);

    // enable dropped mid-frame
    p0 = rd_ptr;
    push(8'h3C, 1'b0, 1);
    push(8'h81, 1'b0, 1);
    wait_busy(1'b1, 10, "en_busy_rise");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, FC + 10, "en_busy_fall");
    repeat (20) @(negedge clk);
    check("en_hold_pops", 32'(rd_ptr - p0), 32'd1);
    check("en_hold_busy", 32'(busy), 32'd0);
    check("en_hold_tx", 32'(tx), 32'd1);
    check("en_hold_bytes_sent", 32'(bytes_sent), 32'd5);
    enable = 1'b1;
    wait_busy(1'b1, 10, "en_resume_rise");
    wait_busy(1'b0, FC + 10, "en_resume_fall");
    check("en_resume_pops", 32'(rd_ptr - p0), 32'd2);
    check("en_resume_bytes_sent", 32'(bytes_sent), 32'd6);

    // reset during DATA bit 3 of 0x96 (that byte is lost)
    repeat (2) @(negedge clk);
    push(8'h96, 1'b0, 0);
    push(8'h5A, 1'b0, 1);
    wait_busy(1'b1, 10, "rst_busy_rise");
    repeat (17) @(negedge clk);
    check("rst_pre_tx_bit3", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_bytes_sent", 32'(bytes_sent), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "rst_after_rise");
    check("rst_after_start", 32'(tx), 32'd0);
    count_busy(n);
    check("rst_after_busy_len", 32'(n), 32'(FC));
    check("rst_after_bytes_sent", 32'(bytes_sent), 32'd1);

`ifdef LOGGER_UART_TX_PARITY_EN
    // parity frames
    repeat (2) @(negedge clk);
    push(8'h07, 1'b1, 1);
    push(8'h03, 1'b0, 1);
    wait_busy(1'b1, 10, "par_busy_rise");
    count_busy(n);
    check("par_busy_len", 32'(n), 32'(2 * 11 * CPB));
    check("par_bytes_sent", 32'(bytes_sent), 32'd3);
`endif

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logger_uart_tx.md
Name: logger_uart_tx

Overview:
- Drain side of the logger byte FIFO. Pops bytes from the FWFT FIFO read port and serialises each one as an asynchronous UART frame on a single TX pin: 8 data bits, LSB first, idle high.
- Sits between the logger FIFO and the board UART pin. It is the only consumer of the FIFO's rd_en/dout/empty.

Parameters:
- CLKS_PER_BIT, 1085, clk cycles per UART bit (125 MHz / 115200). Legal range ≥ 2.
- STOP_BITS, 1, number of stop bits. Legal values 1 or 2.

Ports:
- clk  input  1  system clock, same clock as the logger FIFO
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  when low, no new byte is popped; a frame already in progress completes
- fifo_empty  input  1  FIFO empty flag (FWFT)
- fifo_dout  input  8  FIFO head byte, valid whenever fifo_empty=0
- fifo_rd_en  output  1  pop strobe to FIFO, one cycle per byte
- tx  output  1  UART serial out, idle high
- busy  output  1  high from the cycle after a pop until the last stop-bit cycle, inclusive
- bytes_sent  output  16  count of completed frames; wraps at 0xFFFF→0

Behaviour:
- Reset (rst_n=0, asynchronous assertion):
  - tx=1, fifo_rd_en=0, busy=0, bytes_sent=0, state=IDLE, counters 0.
  - A frame in flight is abandoned and its byte is lost.
  - Reset deassertion is synchronised externally.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- Pop rule:
  - fifo_rd_en is combinational: (state==IDLE or last cycle of STOP) && enable && !fifo_empty.
  - On that clock edge, fifo_dout is latched into an 8-bit shift register and the next state is START.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx is registered and changes only on bit boundaries.
- Per-state behaviour:
  - START: tx=0 for one bit time, then DATA.
  - DATA: tx = shift_reg[0]; shift right at the end of each bit. A bit index 0..7 advances per bit. After bit 7, go to PARITY (if enabled) or STOP.
  - STOP: tx=1 for STOP_BITS bit times. On the last STOP cycle, bytes_sent increments. Next state is START if a pop occurs that cycle (back-to-back, zero idle gap), otherwise IDLE.
- Latency: pop edge to tx falling edge is 1 cycle. Full frame is (10 + STOP_BITS − 1 [+1 parity]) × CLKS_PER_BIT cycles.
- enable deasserted mid-frame: the frame finishes normally, then the block stays in IDLE.
- fifo_empty rising mid-frame: no effect on the current frame.
- fifo_dout changes after the pop: ignored, because the data is already latched.
- bytes_sent wrap: 0xFFFF + 1 = 0x0000, with no saturation.

Optional Feature:
- LOGGER_UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after DATA. tx = XOR of the 8 latched data bits (even parity) for one bit time. Frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic. Frame is 8N1 (or 8N2 with STOP_BITS=2).

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1 → fifo_rd_en is high for exactly 1 cycle; tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; bytes_sent=1; busy low after 40 cycles.
- FIFO holds 0x00, 0xFF, 0x55 back-to-back → 3 contiguous frames with no idle cycle between the stop bit and the next start bit; 3 pops; bytes_sent=3.
- Empty FIFO, enable=1 for 100 cycles → tx stays 1, fifo_rd_en stays 0, busy stays 0.
- Drop enable 10 cycles into the frame for 0x3C with 2 bytes queued → 0x3C frame completes; no further pop until enable returns; then the next byte is sent.
- Assert rst_n=0 during DATA bit 3 → tx=1 immediately (asynchronous, same cycle); bytes_sent=0; after release, the next queued byte is sent cleanly from START.
- With LOGGER_UART_TX_PARITY_EN defined, send 0x07 → parity bit = 1 and frame = 11 bits; send 0x03 → parity bit = 0.
